// File: rtl/snn_pkg.sv
//------------------------------------------------------------------------------
// snn_pkg : shared types and sizing helpers for the spike-coding blocks
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package snn_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } dec_state_t;

  // Width of a counter that spans 0..window-1; never narrower than one bit.
  function automatic int win_width(input int window);
    return (window < 2) ? 1 : $clog2(window);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spike_edge.sv
//------------------------------------------------------------------------------
// spike_edge : registers the previous spike level and flags rising edges
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spike_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic sig_edge
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= sig;
    end
  end

  assign sig_edge = sig & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/spike_rate_decoder.sv
//------------------------------------------------------------------------------
// spike_rate_decoder : counts spike rising edges per fixed window and publishes
//                      the count and a threshold decision over valid/ready
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int WINDOW    = 1024,
  parameter int CNT_WIDTH = 10,
  parameter int THRESH    = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 spike_in,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 above_thresh,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overrun
);

  localparam int                   c_win_w   = win_width(WINDOW);
  localparam logic [c_win_w-1:0]   c_last    = c_win_w'(WINDOW - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

  dec_state_t           r_state;
  dec_state_t           w_state_nxt;
  logic [c_win_w-1:0]   r_win;
  logic [c_win_w-1:0]   w_win_nxt;
  logic [CNT_WIDTH-1:0] r_spk;
  logic [CNT_WIDTH-1:0] w_spk_nxt;
  logic [CNT_WIDTH-1:0] w_final;
  logic                 w_final_above;
  logic [CNT_WIDTH-1:0] r_count_out;
  logic                 r_above;
  logic                 r_valid;
  logic                 r_overrun;
  logic                 w_edge;
  logic                 w_slot_free;
  logic                 w_publish;
  logic                 w_drop;
  logic                 w_valid_nxt;

  spike_edge u_edge (
    .clk      (clk),
    .rst      (rst),
    .sig      (spike_in),
    .sig_edge (w_edge)
  );

  // Count including this cycle's edge, held at full scale rather than wrapping.
  assign w_final       = (r_spk == c_cnt_max) ? r_spk : r_spk + CNT_WIDTH'(w_edge);
  assign w_final_above = (int'(w_final) >= THRESH);
  assign w_slot_free   = ~r_valid | ready;

  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_spk_nxt   = r_spk;
    w_publish   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        w_win_nxt = '0;
        w_spk_nxt = '0;
        if (en) w_state_nxt = COUNT;
      end
      COUNT: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_win_nxt   = '0;
          w_spk_nxt   = '0;
        end else if (r_win == c_last) begin
          w_win_nxt = '0;
          w_spk_nxt = '0;
          w_publish = w_slot_free;
          w_drop    = ~w_slot_free;
        end else begin
          w_win_nxt = r_win + c_win_w'(1);
          w_spk_nxt = w_final;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A publish in the same cycle as an accept keeps valid high with new data.
    w_valid_nxt = w_publish | (r_valid & ~ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_win       <= '0;
      r_spk       <= '0;
      r_count_out <= '0;
      r_above     <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
      r_spk   <= w_spk_nxt;
      r_valid <= w_valid_nxt;
      if (w_publish) begin
        r_count_out <= w_final;
        r_above     <= w_final_above;
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign count_out    = r_count_out;
  assign above_thresh = r_above;
  assign valid        = r_valid;
  assign overrun      = r_overrun;

endmodule

`default_nettype wire
